// File: rtl/regfile_sb.sv
// ============================================================================
// Module      : regfile_sb
// Description : Parametrised register bank with per-register pending
//               scoreboard and a sequential clear engine. Optional same-cycle
//               write-to-read forwarding when REGFILE_SB_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int NRP      = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_req,
  output logic                ready,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_pend,
  output logic [NREG-1:0]     pend_vec
);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [NREG-1:0]   pend_q, pend_d;
  logic [XLEN-1:0]   mem_q [NREG];

  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [XLEN-1:0]   mem_wd;
  logic              wzero;
  logic              czero;

  assign wzero = ZERO_REG && (waddr == '0);
  assign czero = ZERO_REG && (claim_addr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    mem_we  = 1'b0;
    mem_wa  = waddr;
    mem_wd  = wdata;
    case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == LAST_IDX) state_d = READY;
      end
      READY: begin
        if (init_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          pend_d  = '0;
        end else begin
          if (we && !wzero) begin
            mem_we        = 1'b1;
            pend_d[waddr] = 1'b0;
          end
          // Claim applied after the release so a same-edge claim wins.
          if (claim_en && !czero) pend_d[claim_addr] = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  assign ready    = (state_q == READY);
  assign pend_vec = pend_q;

  for (genvar i = 0; i < NRP; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rval;
    logic            rpnd;

    assign ra = rd_addr[i*AW +: AW];

    always_comb begin
      rval = '0;
      rpnd = 1'b0;
      if (state_q == READY) begin
        rval = (ZERO_REG && (ra == '0)) ? '0 : mem_q[ra];
        rpnd = pend_q[ra];
`ifdef REGFILE_SB_BYPASS_EN
        if (we && (ra == waddr) && !wzero) begin
          rval = wdata;
          rpnd = claim_en && (claim_addr == ra);
        end
`endif
      end
    end

    assign rd_data[i*XLEN +: XLEN] = rval;
    assign rd_pend[i]              = rpnd;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module      : tb_regfile_sb
// Description : Bench for regfile_sb; drives a default instance and a
//               64-bit/16-entry/3-port/no-zero-register instance in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        init_r, we_r, ce_r;
  logic [4:0]  wa_r, ca_r;
  logic [63:0] wd_r;
  logic [4:0]  ra_r [3];

  logic        rdy0, rdy1;
  logic [63:0] rdata0;
  logic [191:0] rdata1;
  logic [1:0]  rpend0;
  logic [2:0]  rpend1;
  logic [31:0] pvec0;
  logic [15:0] pvec1;

  int nchk  = 0;
  int nfail = 0;

  regfile_sb #(.XLEN(32), .NREG(32), .NRP(2), .ZERO_REG(1'b1)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_req   (init_r),
    .ready      (rdy0),
    .we         (we_r),
    .waddr      (wa_r),
    .wdata      (wd_r[31:0]),
    .claim_en   (ce_r),
    .claim_addr (ca_r),
    .rd_addr    ({ra_r[1], ra_r[0]}),
    .rd_data    (rdata0),
    .rd_pend    (rpend0),
    .pend_vec   (pvec0)
  );

  regfile_sb #(.XLEN(64), .NREG(16), .NRP(3), .ZERO_REG(1'b0)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_req   (init_r),
    .ready      (rdy1),
    .we         (we_r),
    .waddr      (wa_r[3:0]),
    .wdata      (wd_r),
    .claim_en   (ce_r),
    .claim_addr (ca_r[3:0]),
    .rd_addr    ({ra_r[2][3:0], ra_r[1][3:0], ra_r[0][3:0]}),
    .rd_data    (rdata1),
    .rd_pend    (rpend1),
    .pend_vec   (pvec1)
  );

  // Reference state per instance: k=0 default build, k=1 swept build.
  logic [63:0] mm [2][32];
  logic [31:0] mp [2];
  bit          mr [2];
  int          mc [2];

  function automatic int nr(int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic bit zr(int k);
    return (k == 0);
  endfunction

  function automatic logic [63:0] dmask(int k);
    return (k == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mr[k] = 1'b0;
      mc[k] = 0;
      mp[k] = '0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int a, c;
      a = int'(wa_r) & (nr(k) - 1);
      c = int'(ca_r) & (nr(k) - 1);
      if (!mr[k]) begin
        mm[k][mc[k]] = '0;
        mc[k]++;
        if (mc[k] == nr(k)) mr[k] = 1'b1;
      end else if (init_r) begin
        mr[k] = 1'b0;
        mc[k] = 0;
        mp[k] = '0;
      end else begin
        if (we_r && !(zr(k) && a == 0)) begin
          mm[k][a] = wd_r & dmask(k);
          mp[k][a] = 1'b0;
        end
        if (ce_r && !(zr(k) && c == 0)) mp[k][c] = 1'b1;
      end
    end
  endtask

  function automatic logic [63:0] exp_data(int k, int p);
    int r, a;
    r = int'(ra_r[p]) & (nr(k) - 1);
    a = int'(wa_r) & (nr(k) - 1);
    if (!mr[k]) return '0;
    if (zr(k) && r == 0) return '0;
`ifdef REGFILE_SB_BYPASS_EN
    if (we_r && r == a) return wd_r & dmask(k);
`endif
    return mm[k][r];
  endfunction

  function automatic logic exp_pend(int k, int p);
    int r, a, c;
    r = int'(ra_r[p]) & (nr(k) - 1);
    a = int'(wa_r) & (nr(k) - 1);
    c = int'(ca_r) & (nr(k) - 1);
    if (!mr[k]) return 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
    if (we_r && r == a && !(zr(k) && r == 0)) return ce_r && (c == r);
`endif
    return mp[k][r];
  endfunction

  task automatic check_all();
    check_val("ready0", 64'(rdy0), 64'(mr[0]));
    check_val("ready1", 64'(rdy1), 64'(mr[1]));
    check_val("pend_vec0", 64'(pvec0), 64'(mp[0]));
    check_val("pend_vec1", 64'(pvec1), 64'(mp[1][15:0]));
    for (int p = 0; p < 2; p++) begin
      check_val($sformatf("rd_data0[%0d]", p), 64'(rdata0[p*32 +: 32]), exp_data(0, p));
      check_val($sformatf("rd_pend0[%0d]", p), 64'(rpend0[p]), 64'(exp_pend(0, p)));
    end
    for (int p = 0; p < 3; p++) begin
      check_val($sformatf("rd_data1[%0d]", p), rdata1[p*64 +: 64], exp_data(1, p));
      check_val($sformatf("rd_pend1[%0d]", p), 64'(rpend1[p]), 64'(exp_pend(1, p)));
    end
  endtask

  task automatic step(input bit i, input bit w, input logic [4:0] a, input logic [63:0] d,
                      input bit c, input logic [4:0] ca,
                      input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    init_r  = i;
    we_r    = w;
    wa_r    = a;
    wd_r    = d;
    ce_r    = c;
    ca_r    = ca;
    ra_r[0] = r0;
    ra_r[1] = r1;
    ra_r[2] = r2;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rand_step();
    logic [4:0] a, r [3];
    a = 5'($urandom);
    for (int p = 0; p < 3; p++) r[p] = ($urandom_range(3) == 0) ? a : 5'($urandom);
    step(($urandom_range(99) == 0), 1'($urandom), a, {$urandom, $urandom},
         ($urandom_range(99) < 40), 5'($urandom), r[0], r[1], r[2]);
  endtask

  // Asserts reset between edges so its effect is seen before any clock.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b1;
    init_r = 1'b0;
    we_r   = 1'b0;
    ce_r   = 1'b0;
    wa_r   = '0;
    ca_r   = '0;
    wd_r   = '0;
    for (int p = 0; p < 3; p++) ra_r[p] = '0;
    #2;
    do_reset();

    repeat (34) rand_step();
    repeat (40) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    step(0, 1, 5,  64'h0000_0000_DEAD_BEEF, 0, 0, 0, 0, 0);
    step(0, 1, 31, 64'h0000_0000_1234_5678, 0, 0, 0, 0, 0);
    step(0, 0, 0,  0, 0, 0, 5, 31, 5);
    step(0, 1, 0,  64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0);
    step(0, 0, 0,  0, 0, 0, 0, 0, 0);
    step(0, 0, 0,  0, 1, 7, 7, 7, 7);
    step(0, 0, 0,  0, 0, 0, 7, 7, 7);
    step(0, 1, 7,  64'h77, 0, 0, 7, 0, 0);
    step(0, 0, 0,  0, 0, 0, 7, 7, 7);
    step(0, 1, 9,  64'h99, 1, 9, 9, 9, 0);
    step(0, 0, 0,  0, 0, 0, 9, 9, 9);
    step(0, 1, 12, 64'h0000_0000_CAFE_F00D, 0, 0, 0, 12, 12);
    step(0, 0, 0,  0, 0, 0, 12, 12, 12);

    step(0, 1, 3,  64'h0000_0000_A5A5_A5A5, 0, 0, 0, 0, 0);
    step(0, 0, 0,  0, 1, 4, 3, 4, 0);
    step(1, 1, 5,  64'h55, 1, 6, 3, 4, 5);
    repeat (32) step(0, 1, 3, 64'h1111, 1, 4, 3, 4, 0);
    step(0, 0, 0,  0, 0, 0, 3, 4, 3);

    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      rand_step();
    end

    repeat (40) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 32; n++)
      step(0, 0, 0, 0, 0, 0, 5'(n), 5'(n ^ 1), 5'(n + 7));

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

`default_nettype wire
